// File: rtl/matrix_print_sequencer_pkg.sv
// Shared types and constants for the matrix print sequencer.
// Holds the element type, size limits and the FSM state enum.
package matrix_print_sequencer_pkg;

  localparam int MAX_DIM = 5;
  localparam int ADDR_W  = 5;
  localparam int ELEM_W  = 8;

  typedef logic signed [ELEM_W-1:0] matrix_element_t;

  typedef enum logic [3:0] {
    PS_IDLE,
    PS_CHECK,
    PS_ID_REQ,
    PS_ID_WAIT,
    PS_RD_ISSUE,
    PS_RD_WAIT,
    PS_EL_REQ,
    PS_EL_WAIT,
    PS_NL_REQ,
    PS_NL_WAIT,
    PS_FINISH
  } print_seq_state_t;

  function automatic logic dim_ok(
    input logic [2:0] d,
    input int         max_dim
  );
    return (d != 3'd0) && (int'(d) <= max_dim);
  endfunction

endpackage

// File: rtl/matrix_print_sequencer_if.sv
// Storage read port plus sender request/done handshake.
// master = sequencer side, slave = memory/sender side.
interface matrix_print_sequencer_if #(
  parameter int ADDR_W = matrix_print_sequencer_pkg::ADDR_W
);
  import matrix_print_sequencer_pkg::*;

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  matrix_element_t   mem_rd_data;
  logic              snd_start;
  logic              snd_send_newline;
  logic              snd_send_id;
  matrix_element_t   snd_data;
  logic              snd_is_last_col;
  logic              snd_done;

  modport master (
    output mem_rd_en,
    output mem_rd_addr,
    input  mem_rd_data,
    output snd_start,
    output snd_send_newline,
    output snd_send_id,
    output snd_data,
    output snd_is_last_col,
    input  snd_done
  );

  modport slave (
    input  mem_rd_en,
    input  mem_rd_addr,
    output mem_rd_data,
    input  snd_start,
    input  snd_send_newline,
    input  snd_send_id,
    input  snd_data,
    input  snd_is_last_col,
    output snd_done
  );

endinterface

// File: rtl/matrix_print_sequencer.sv
// Walks a stored matrix row-major, one sender request per element.
// Ports: clk/rst_n, start+dims/id control, status, bus (mem+sender).
module matrix_print_sequencer #(
  parameter int MAX_DIM = matrix_print_sequencer_pkg::MAX_DIM,
  parameter int ADDR_W  = matrix_print_sequencer_pkg::ADDR_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic [2:0] rows,
  input  logic [2:0] cols,
  input  matrix_print_sequencer_pkg::matrix_element_t mat_id,
  input  logic with_id,
  input  logic abort,
  output logic busy,
  output logic done,
  output logic aborted,
  output logic err,
  matrix_print_sequencer_if.master bus
);
  import matrix_print_sequencer_pkg::*;

  print_seq_state_t state_q, state_d;

  logic [2:0] rows_q, rows_d;
  logic [2:0] cols_q, cols_d;
  logic [2:0] r_q, r_d;
  logic [2:0] c_q, c_d;

  matrix_element_t id_q, id_d;
  matrix_element_t data_q, data_d;

  logic with_id_q, with_id_d;
  logic last_q, last_d;
  logic sid_q, sid_d;
  logic abort_q, abort_d;
  logic aborted_q, aborted_d;

  logic abort_pend;
  logic last_c;
  logic last_r;
  logic rd_en;

  assign abort_pend = abort_q | abort;
  assign last_c     = (c_q == cols_q - 3'd1);
  assign last_r     = (r_q == rows_q - 3'd1);

  always_comb begin
    state_d   = state_q;
    rows_d    = rows_q;
    cols_d    = cols_q;
    r_d       = r_q;
    c_d       = c_q;
    id_d      = id_q;
    data_d    = data_q;
    with_id_d = with_id_q;
    last_d    = last_q;
    sid_d     = sid_q;
    aborted_d = aborted_q;
    // pending abort lives only while busy
    abort_d   = (state_q == PS_IDLE) ? 1'b0 : abort_pend;

    busy                 = (state_q != PS_IDLE);
    done                 = 1'b0;
    err                  = 1'b0;
    rd_en                = 1'b0;
    bus.snd_start        = 1'b0;
    bus.snd_send_newline = 1'b0;

    unique case (state_q)
      PS_IDLE: begin
        if (start) begin
          rows_d    = rows;
          cols_d    = cols;
          id_d      = mat_id;
          with_id_d = with_id;
          r_d       = 3'd0;
          c_d       = 3'd0;
          aborted_d = 1'b0;
          state_d   = PS_CHECK;
        end
      end
      PS_CHECK: begin
        if (!dim_ok(rows_q, MAX_DIM) ||
            !dim_ok(cols_q, MAX_DIM)) begin
          err     = 1'b1;
          state_d = PS_IDLE;
        end else if (abort_pend) begin
          aborted_d = 1'b1;
          state_d   = PS_FINISH;
        end else if (with_id_q) begin
          data_d  = id_q;
          sid_d   = 1'b1;
          last_d  = 1'b1;
          state_d = PS_ID_REQ;
        end else begin
          state_d = PS_RD_ISSUE;
        end
      end
      PS_ID_REQ: begin
        if (abort_pend) begin
          aborted_d = 1'b1;
          state_d   = PS_FINISH;
        end else begin
          bus.snd_start = 1'b1;
          state_d       = PS_ID_WAIT;
        end
      end
      PS_ID_WAIT: begin
        if (bus.snd_done) begin
          sid_d   = 1'b0;
          state_d = PS_RD_ISSUE;
        end
      end
      PS_RD_ISSUE: begin
        if (abort_pend) begin
          aborted_d = 1'b1;
          state_d   = PS_FINISH;
        end else begin
          rd_en   = 1'b1;
          state_d = PS_RD_WAIT;
        end
      end
      PS_RD_WAIT: begin
        // read data is valid exactly this cycle
        data_d = bus.mem_rd_data;
        last_d = last_c;
        sid_d  = 1'b0;
        if (abort_pend) begin
          aborted_d = 1'b1;
          state_d   = PS_FINISH;
        end else begin
          state_d = PS_EL_REQ;
        end
      end
      PS_EL_REQ: begin
        if (abort_pend) begin
          aborted_d = 1'b1;
          state_d   = PS_FINISH;
        end else begin
          bus.snd_start = 1'b1;
          state_d       = PS_EL_WAIT;
        end
      end
      PS_EL_WAIT: begin
        if (bus.snd_done) begin
          if (abort_pend) begin
            aborted_d = 1'b1;
            state_d   = PS_FINISH;
          end else if (!last_c) begin
            c_d     = c_q + 3'd1;
            state_d = PS_RD_ISSUE;
          end else if (!last_r) begin
            c_d     = 3'd0;
            r_d     = r_q + 3'd1;
            state_d = PS_RD_ISSUE;
          end else begin
            state_d = PS_NL_REQ;
          end
        end
      end
      PS_NL_REQ: begin
        if (abort_pend) begin
          aborted_d = 1'b1;
          state_d   = PS_FINISH;
        end else begin
          bus.snd_send_newline = 1'b1;
          state_d              = PS_NL_WAIT;
        end
      end
      PS_NL_WAIT: begin
        if (bus.snd_done) begin
          aborted_d = abort_pend;
          state_d   = PS_FINISH;
        end
      end
      PS_FINISH: begin
        done    = 1'b1;
        state_d = PS_IDLE;
      end
      default: begin
        state_d = PS_IDLE;
      end
    endcase
  end

  assign aborted              = (state_q == PS_FINISH) & aborted_q;
  assign bus.mem_rd_en        = rd_en;
  assign bus.snd_send_id      = sid_q;
  assign bus.snd_data         = data_q;
  assign bus.snd_is_last_col  = last_q;
  assign bus.mem_rd_addr      = rd_en ?
    ADDR_W'(int'(r_q) * MAX_DIM + int'(c_q)) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= PS_IDLE;
      rows_q    <= '0;
      cols_q    <= '0;
      r_q       <= '0;
      c_q       <= '0;
      id_q      <= '0;
      data_q    <= '0;
      with_id_q <= 1'b0;
      last_q    <= 1'b0;
      sid_q     <= 1'b0;
      abort_q   <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rows_q    <= rows_d;
      cols_q    <= cols_d;
      r_q       <= r_d;
      c_q       <= c_d;
      id_q      <= id_d;
      data_q    <= data_d;
      with_id_q <= with_id_d;
      last_q    <= last_d;
      sid_q     <= sid_d;
      abort_q   <= abort_d;
      aborted_q <= aborted_d;
    end
  end

endmodule

// File: tb/tb_matrix_print_sequencer.sv
// Directed bench: memory model, 3-cycle sender model, scoreboard
// of expected requests and read addresses.
module tb_matrix_print_sequencer;
  import matrix_print_sequencer_pkg::*;

  typedef struct {
    int kind;
    int data;
    int last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic [2:0] rows;
  logic [2:0] cols;
  matrix_element_t mat_id;
  logic with_id;
  logic abort;
  logic busy;
  logic done;
  logic aborted;
  logic err;

  matrix_print_sequencer_if bus ();

  matrix_print_sequencer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .rows    (rows),
    .cols    (cols),
    .mat_id  (mat_id),
    .with_id (with_id),
    .abort   (abort),
    .busy    (busy),
    .done    (done),
    .aborted (aborted),
    .err     (err),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  matrix_element_t mem [32];
  exp_t exp_q [$];
  int   addr_q [$];
  exp_t cur;
  int   outstanding = 0;
  int   rd_cnt = 0;
  int   req_cnt = 0;
  int   done_cnt = 0;
  int   err_cnt = 0;
  int   snd_cnt;

  task automatic chk(
    input string tag,
    input logic signed [31:0] obs,
    input logic signed [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    if (bus.mem_rd_en)
      bus.mem_rd_data <= mem[bus.mem_rd_addr];
  end

  always @(posedge clk) begin
    bus.snd_done <= 1'b0;
    if (!rst_n) begin
      snd_cnt <= 0;
    end else if (bus.snd_start || bus.snd_send_newline) begin
      snd_cnt <= 3;
    end else if (snd_cnt != 0) begin
      snd_cnt <= snd_cnt - 1;
      if (snd_cnt == 1)
        bus.snd_done <= 1'b1;
    end
  end

  always @(negedge clk) begin : mon
    int k;
    if (rst_n === 1'b1) begin
      if (bus.mem_rd_en) begin
        rd_cnt++;
        if (addr_q.size() == 0)
          chk("rd_extra", addr_q.size(), 1);
        else
          chk("rd_addr", bus.mem_rd_addr, addr_q.pop_front());
      end
      if (bus.snd_start || bus.snd_send_newline) begin
        req_cnt++;
        chk("one_outstanding", outstanding, 0);
        outstanding = 1;
        k = bus.snd_send_newline ? 2 : (bus.snd_send_id ? 1 : 0);
        if (exp_q.size() == 0) begin
          chk("req_extra", exp_q.size(), 1);
          cur = '{kind: k, data: 0, last: 0};
        end else begin
          cur = exp_q.pop_front();
          chk("req_kind", k, cur.kind);
          chk("req_both", bus.snd_start & bus.snd_send_newline, 0);
          if (cur.kind != 2) begin
            chk("req_data", bus.snd_data, cur.data);
            chk("req_last", bus.snd_is_last_col, cur.last);
          end
        end
      end
      if (bus.snd_done && outstanding != 0) begin
        outstanding = 0;
        if (cur.kind != 2) begin
          chk("hold_data", bus.snd_data, cur.data);
          chk("hold_last", bus.snd_is_last_col, cur.last);
          chk("hold_id", bus.snd_send_id, int'(cur.kind == 1));
        end
      end
      if (done) done_cnt++;
      if (err) err_cnt++;
    end
  end

  task automatic push_el(input int d, input int l);
    exp_q.push_back('{kind: 0, data: d, last: l});
  endtask

  task automatic push_nl();
    exp_q.push_back('{kind: 2, data: 0, last: 0});
  endtask

  task automatic load_2x3();
    mem[0] = 8'sd1;
    mem[1] = -8'sd2;
    mem[2] = 8'sd3;
    mem[5] = 8'sd40;
    mem[6] = -8'sd128;
    mem[7] = 8'sd127;
  endtask

  task automatic exp_2x3();
    push_el(1, 0);
    push_el(-2, 0);
    push_el(3, 1);
    push_el(40, 0);
    push_el(-128, 0);
    push_el(127, 1);
    push_nl();
    addr_q = '{0, 1, 2, 5, 6, 7};
  endtask

  task automatic pulse_start(
    input int r, input int c,
    input int id, input logic wid
  );
    @(posedge clk) #1;
    rows = 3'(r);
    cols = 3'(c);
    mat_id = 8'(id);
    with_id = wid;
    start = 1'b1;
    @(posedge clk) #1;
    start = 1'b0;
  endtask

  task automatic wait_end(input string tag, input logic exp_ab);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done || err) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_timeout"}, ok, 1);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_aborted"}, aborted, exp_ab);
    chk({tag, "_busy_at_done"}, busy, 1);
    chk({tag, "_q_left"}, exp_q.size(), 0);
    chk({tag, "_addr_left"}, addr_q.size(), 0);
    @(negedge clk);
    chk({tag, "_busy_after"}, busy, 0);
  endtask

  task automatic wait_req(input int target);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
    chk("wait_req_timeout", ok, 1);
  endtask

  function automatic logic [21:0] outs();
    return {busy, done, aborted, err, bus.mem_rd_en,
            bus.mem_rd_addr, bus.snd_start,
            bus.snd_send_newline, bus.snd_send_id,
            bus.snd_data, bus.snd_is_last_col};
  endfunction

  initial begin
    int d0;
    int a0;
    rst_n = 1'b0;
    start = 1'b0;
    rows = '0;
    cols = '0;
    mat_id = '0;
    with_id = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", outs(), 0);
    @(posedge clk) #1;
    rst_n = 1'b1;

    // 2x3 plain print
    load_2x3();
    exp_2x3();
    d0 = done_cnt;
    pulse_start(2, 3, 0, 1'b0);
    wait_end("m2x3", 1'b0);
    chk("m2x3_done_cnt", done_cnt - d0, 1);

    // 1x1 with ID line
    mem[0] = 8'sd7;
    exp_q.push_back('{kind: 1, data: 3, last: 1});
    push_el(7, 1);
    push_nl();
    addr_q = '{0};
    pulse_start(1, 1, 3, 1'b1);
    wait_end("m1x1id", 1'b0);

    // bad dimensions
    a0 = rd_cnt + req_cnt;
    d0 = err_cnt;
    pulse_start(0, 3, 0, 1'b0);
    @(negedge clk);
    chk("rows0_err", err, 1);
    chk("rows0_busy", busy, 1);
    @(negedge clk);
    chk("rows0_idle", {busy, err}, 0);
    pulse_start(2, 6, 0, 1'b0);
    @(negedge clk);
    chk("cols6_err", err, 1);
    @(negedge clk);
    chk("cols6_idle", {busy, err}, 0);
    chk("err_cnt", err_cnt - d0, 2);
    chk("err_no_activity", rd_cnt + req_cnt - a0, 0);

    // 3x3 with abort in the 2nd element wait
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        mem[r * 5 + c] = 8'(r * 3 + c + 10);
    push_el(10, 0);
    push_el(11, 0);
    addr_q = '{0, 1};
    a0 = req_cnt;
    pulse_start(3, 3, 0, 1'b0);
    wait_req(a0 + 2);
    @(posedge clk) #1;
    abort = 1'b1;
    @(posedge clk) #1;
    abort = 1'b0;
    wait_end("abort", 1'b1);
    chk("abort_req_cnt", req_cnt - a0, 2);

    // start re-pulsed mid-print is ignored
    load_2x3();
    exp_2x3();
    a0 = req_cnt;
    pulse_start(2, 3, 0, 1'b0);
    wait_req(a0 + 1);
    @(posedge clk) #1;
    rows = 3'd1;
    cols = 3'd1;
    start = 1'b1;
    @(posedge clk) #1;
    start = 1'b0;
    wait_end("restart", 1'b0);
    chk("restart_req_cnt", req_cnt - a0, 7);

    // reset during element wait
    exp_2x3();
    a0 = req_cnt;
    d0 = done_cnt;
    pulse_start(2, 3, 0, 1'b0);
    wait_req(a0 + 1);
    @(posedge clk) #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_outputs", outs(), 0);
    exp_q.delete();
    addr_q.delete();
    outstanding = 0;
    @(posedge clk) #1;
    rst_n = 1'b1;
    chk("midrst_no_done", done_cnt - d0, 0);
    push_el(1, 1);
    push_nl();
    addr_q = '{0};
    pulse_start(1, 1, 0, 1'b0);
    wait_end("postrst", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matrix_print_sequencer.md
Name: matrix_print_sequencer

Overview:
- Upstream feeder for matrix_uart_sender. Walks one stored matrix in row-major order and issues one sender request per element, with optional ID line and trailing blank line.
- Reads elements from matrix storage through a 1-cycle-latency read port.
- Shared by matrix display and result output; consumers only pulse start and wait for done.

Parameters:
- MAX_DIM, 5, maximum rows/cols.
- ADDR_W, 5, storage address width; must satisfy 2^ADDR_W >= MAX_DIM*MAX_DIM.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- start  in  1  one-cycle request; ignored unless idle
- rows  in  3  row count, latched on start
- cols  in  3  column count, latched on start
- mat_id  in  matrix_element_t  ID value, latched on start
- with_id  in  1  print ID line first, latched on start
- abort  in  1  stop after current sender transaction
- busy  out  1  high from accepted start until done/err cycle inclusive
- done  out  1  one-cycle completion pulse
- aborted  out  1  valid with done; 1 if terminated by abort
- err  out  1  one-cycle pulse, bad dimensions
- mem_rd_en  out  1  read strobe
- mem_rd_addr  out  ADDR_W  element address = r*MAX_DIM + c
- mem_rd_data  in  matrix_element_t  valid the cycle after mem_rd_en
- snd_start  out  1  element request pulse
- snd_send_newline  out  1  newline-only request pulse
- snd_send_id  out  1  ID mode level
- snd_data  out  matrix_element_t  value to print
- snd_is_last_col  out  1  row-end level
- snd_done  in  1  sender completion pulse

Behaviour:
- Reset (sync): state IDLE; all outputs 0; row/col counters 0. Reset mid-print drops the transaction immediately. No done pulse.
- IDLE + start: latch inputs and assert busy next cycle.
  - rows or cols equal to 0 or greater than MAX_DIM → err=1 in the CHECK cycle, then IDLE. No memory or sender activity.
- States: IDLE, CHECK, ID_REQ, ID_WAIT, RD_ISSUE, RD_WAIT, EL_REQ, EL_WAIT, NL_REQ, NL_WAIT, FINISH.
- CHECK → ID_REQ if with_id, else RD_ISSUE.
- ID_REQ: snd_start=1 for one cycle; snd_data=mat_id, snd_send_id=1, snd_is_last_col=1. Then ID_WAIT until snd_done, then RD_ISSUE.
- RD_ISSUE: mem_rd_en=1 for one cycle with the addr of (r,c), then RD_WAIT. RD_WAIT captures mem_rd_data into snd_data, then EL_REQ.
- EL_REQ: snd_start=1 for one cycle; snd_is_last_col=(c==cols-1); snd_send_id=0. Then EL_WAIT.
- EL_WAIT on snd_done, advancing in this priority order:
  - abort pending → FINISH with aborted=1.
  - c<cols-1 → c++, RD_ISSUE.
  - r<rows-1 → c=0, r++, RD_ISSUE.
  - otherwise → NL_REQ.
- NL_REQ: snd_send_newline=1 for one cycle → NL_WAIT → on snd_done → FINISH.
- FINISH: done=1 for one cycle, then IDLE with busy=0 on the following cycle.
- Holding rules: snd_data, snd_is_last_col and snd_send_id stay stable from the request cycle through the snd_done cycle. Only one sender request is outstanding at any time. A new request is issued no earlier than 1 cycle after snd_done.
- Abort:
  - Latched as pending when seen while busy; cleared in IDLE.
  - During a WAIT state, the outstanding transaction completes first; the transition to FINISH happens on snd_done.
  - In a non-WAIT busy state, go directly to FINISH; no new request is issued.
  - In IDLE, abort is ignored.
- start while busy is ignored and the latched values are unchanged. A snd_done arriving in a non-WAIT state is ignored.
- Element cycle overhead, excluding sender time: 4 cycles (RD_ISSUE, RD_WAIT, EL_REQ, post-done).

Decomposition:
- project_pkg gets: MAX_DIM constant and the print_seq_state_t enum.
- Reuse the existing matrix_element_t and address-width constants from project_pkg.
- No sub-module. The r/c counter pair is inline logic.

Test Plan:
- Tie the sender model to a fixed 3-cycle snd_done for all scenarios.
- 2x3 matrix {1,-2,3;40,-128,127}, with_id=0 → 6 snd_start pulses; snd_data sequence 1,-2,3,40,-128,127; is_last_col pattern 0,0,1,0,0,1; addresses 0,1,2,5,6,7; then 1 snd_send_newline; then done=1, aborted=0.
- 1x1 matrix {7}, with_id=1, mat_id=3 → first request has snd_send_id=1, data 3, last_col=1; then element 7 with last_col=1; then newline, done.
- rows=0, and separately cols=6 → err pulse 2 cycles after start; no mem_rd_en or snd_* activity; busy low afterwards.
- 3x3 matrix, abort pulsed during the 2nd EL_WAIT → exactly 2 elements sent, no newline request, done=1 with aborted=1.
- start re-pulsed mid-print with rows=1 → output identical to the unperturbed run.
- rst_n low during EL_WAIT → next cycle all outputs 0 and state IDLE; a fresh start afterwards prints correctly.
